// File: rtl/sha_round_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha_pkg
// Description : Shared types and helpers for the SHA-256 round controller:
//               FSM state encoding, SHA-256 initial hash value and the two
//               message-schedule sigma functions.
// Revision    : 1.0 - initial release
// ============================================================================
package sha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  // SHA-256 initial hash value, word a at [31:0] through word h at [255:224]
  localparam logic [255:0] c_sha256_iv = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };

  // ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sha_round_ctrl_if
// Description : Host and datapath signal bundle for sha_round_ctrl.
//   start/abort        : block request and cancel
//   block_in/hash_in   : 512-bit message block, 256-bit chaining value
//   math_input/W/cycle : working state, schedule pair and K-pair index out
//   math_output        : datapath result after two rounds
//   busy/done/hash_out : status and final digest
// Revision    : 1.0 - initial release
// ============================================================================
interface sha_round_ctrl_if;
  logic         start;
  logic         abort;
  logic [511:0] block_in;
  logic [255:0] hash_in;
  logic [255:0] math_input;
  logic [255:0] math_output;
  logic [63:0]  W;
  logic [5:0]   cycle;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;

  modport master (
    output start, abort, block_in, hash_in, math_output,
    input  math_input, W, cycle, busy, done, hash_out
  );

  modport slave (
    input  start, abort, block_in, hash_in, math_output,
    output math_input, W, cycle, busy, done, hash_out
  );
endinterface
`default_nettype wire

// File: rtl/sha_wsched.sv
`default_nettype none
// ============================================================================
// Module      : sha_wsched
// Description : 16-word SHA-256 message schedule window. Loads a block and,
//               when shifting, retires two words and appends two new ones.
//   clk, n_rst : clock, asynchronous active-low reset
//   load       : capture block_in into the window (word 0 at [31:0])
//   shift      : advance the window by two words
//   w_pair     : {window[1], window[0]}
// Revision    : 1.0 - initial release
// ============================================================================
module sha_wsched
  import sha_pkg::*;
(
  input  wire logic         clk,
  input  wire logic         n_rst,
  input  wire logic         load,
  input  wire logic         shift,
  input  wire logic [511:0] block_in,
  output logic      [63:0]  w_pair
);

  logic [31:0] r_window [16];
  logic [31:0] w_new0;
  logic [31:0] w_new1;

  // window[k] holds W[t+k]; these produce W[t+16] and W[t+17]
  assign w_new0 = sigma1(r_window[14]) + r_window[9]  + sigma0(r_window[1]) + r_window[0];
  assign w_new1 = sigma1(r_window[15]) + r_window[10] + sigma0(r_window[2]) + r_window[1];

  assign w_pair = {r_window[1], r_window[0]};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 16; i++) r_window[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) r_window[i] <= block_in[32*i +: 32];
    end else if (shift) begin
      for (int i = 0; i < 14; i++) r_window[i] <= r_window[i+2];
      r_window[14] <= w_new0;
      r_window[15] <= w_new1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sha_round_ctrl
// Description : Sequences an external two-rounds-per-clock SHA-256 datapath
//               over one 512-bit block (32 RUN cycles + 1 FINAL cycle).
//   clk   : system clock, rising edge
//   n_rst : asynchronous active-low reset
//   bus   : sha_round_ctrl_if.slave (host request/status, datapath link)
// Revision    : 1.0 - initial release
// ============================================================================
module sha_round_ctrl
  import sha_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       n_rst,
  sha_round_ctrl_if.slave bus
);

  state_t       r_state;
  state_t       w_next_state;
  logic [4:0]   r_pair_cnt;
  logic [255:0] r_chain;
  logic [255:0] r_work;
  logic [255:0] r_hash_out;
  logic         r_done;
  logic [255:0] w_sum;
  logic         w_load;
  logic         w_shift;
  logic         w_finish;
  logic         w_busy;
  logic [5:0]   w_cycle;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; abort always wins, including over start in IDLE
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start && !bus.abort) w_next_state = ST_RUN;
      ST_RUN: begin
        if (bus.abort)                 w_next_state = ST_IDLE;
        else if (r_pair_cnt == 5'd31)  w_next_state = ST_FINAL;
      end
      ST_FINAL: w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_finish = 1'b0;
    w_busy   = 1'b0;
    w_cycle  = 6'd0;
    case (r_state)
      ST_IDLE:  w_load = bus.start && !bus.abort;
      ST_RUN: begin
        w_busy  = 1'b1;
        w_shift = !bus.abort;
        w_cycle = {1'b0, r_pair_cnt} + 6'd1;
      end
      ST_FINAL: begin
        w_busy   = 1'b1;
        w_finish = !bus.abort;
      end
      default: ;
    endcase
  end

  // Word-wise feed-forward of the chaining value
  for (genvar gi = 0; gi < 8; gi++) begin : g_add
    assign w_sum[32*gi +: 32] = r_chain[32*gi +: 32] + r_work[32*gi +: 32];
  end

  // Working state, chaining value and pair counter. The counter wraps
  // 31 -> 0 on the last shift, which is exactly the edge entering FINAL.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_work     <= '0;
      r_chain    <= '0;
      r_pair_cnt <= '0;
    end else if (w_load) begin
      r_work     <= bus.hash_in;
      r_chain    <= bus.hash_in;
      r_pair_cnt <= '0;
    end else if (w_shift) begin
      r_work     <= bus.math_output;
      r_pair_cnt <= r_pair_cnt + 5'd1;
    end
  end

  // Digest and done pulse are registered so done coincides with valid data
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_hash_out <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) r_hash_out <= w_sum;
    end
  end

  sha_wsched u_wsched (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (w_load),
    .shift    (w_shift),
    .block_in (bus.block_in),
    .w_pair   (bus.W)
  );

  assign bus.math_input = r_work;
  assign bus.cycle      = w_cycle;
  assign bus.busy       = w_busy;
  assign bus.done       = r_done;
  assign bus.hash_out   = r_hash_out;

endmodule
`default_nettype wire

// File: tb/tb_sha_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha_round_ctrl
// Description : Directed self-checking bench for sha_round_ctrl, with a
//               behavioural two-round SHA-256 datapath attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha_round_ctrl;

  localparam logic [255:0] ABC_DIGEST = {
    32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
    32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk;
  logic         n_rst;
  int           n_asserts;
  int           n_fail;
  logic [31:0]  ref_w [64];
  logic [511:0] abc_blk;
  logic [511:0] alt_blk;
  logic [255:0] digest2;
  logic         done_seen;

  sha_round_ctrl_if bus ();

  sha_round_ctrl dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference SHA-256 arithmetic ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ls0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ls1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [255:0] round1(input logic [255:0] st, input logic [31:0] k,
                                          input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    a = st[31:0];    b = st[63:32];   c = st[95:64];   d = st[127:96];
    e = st[159:128]; f = st[191:160]; g = st[223:192]; h = st[255:224];
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {g, f, e, d + t1, c, b, a, t1 + t2};
  endfunction

  function automatic logic [255:0] dp_model(input logic [255:0] st, input logic [63:0] w,
                                            input logic [5:0] cyc);
    int idx;
    logic [255:0] s;
    if (cyc == 6'd0 || cyc > 6'd32) return st;
    idx = 2 * (int'(cyc) - 1);
    s = round1(st, K[idx], w[31:0]);
    return round1(s, K[idx + 1], w[63:32]);
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [255:0] s;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
    for (int t = 16; t < 64; t++) w[t] = ls1(w[t-2]) + w[t-7] + ls0(w[t-15]) + w[t-16];
    s = hin;
    for (int t = 0; t < 64; t++) s = round1(s, K[t], w[t]);
    for (int i = 0; i < 8; i++) r[32*i +: 32] = hin[32*i +: 32] + s[32*i +: 32];
    return r;
  endfunction

  task automatic compute_sched(input logic [511:0] blk);
    for (int t = 0; t < 16; t++) ref_w[t] = blk[32*t +: 32];
    for (int t = 16; t < 64; t++) ref_w[t] = ls1(ref_w[t-2]) + ref_w[t-7] + ls0(ref_w[t-15]) + ref_w[t-16];
  endtask

  // Behavioural datapath
  assign bus.math_output = dp_model(bus.math_input, bus.W, bus.cycle);

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Follows RUN pairs 0..last_j from the first negedge after the start edge.
  // With inject set, start is re-pulsed with another block at pairs 5 and 20.
  task automatic watch_run(input int last_j, input bit inject);
    for (int j = 0; j <= last_j; j++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("run_busy",  256'(bus.busy), 256'(1'b1));
      chk("run_cycle", 256'(bus.cycle), 256'(j + 1));
      chk("run_W",     256'(bus.W), 256'({ref_w[2*j+1], ref_w[2*j]}));
      if (inject && (j == 5 || j == 20)) begin
        bus.start    = 1'b1;
        bus.block_in = alt_blk;
        bus.hash_in  = ~sha_pkg::c_sha256_iv;
      end
    end
  endtask

  // FINAL cycle, then the done cycle
  task automatic expect_done(input logic [255:0] exp);
    @(negedge clk);
    chk("final_busy",  256'(bus.busy), 256'(1'b1));
    chk("final_done",  256'(bus.done), 256'(1'b0));
    chk("final_cycle", 256'(bus.cycle), 256'(6'd0));
    @(negedge clk);
    chk("done_pulse", 256'(bus.done), 256'(1'b1));
    chk("done_busy",  256'(bus.busy), 256'(1'b0));
    chk("digest",     bus.hash_out, exp);
  endtask

  task automatic begin_block(input logic [255:0] hin);
    @(negedge clk);
    bus.hash_in  = hin;
    bus.block_in = abc_blk;
    bus.start    = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_asserts    = 0;
    n_fail       = 0;
    n_rst        = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.block_in = '0;
    bus.hash_in  = '0;
    abc_blk      = '0;
    abc_blk[31:0]    = 32'h61626380;
    abc_blk[511:480] = 32'h00000018;
    alt_blk      = {16{32'hdeadbeef}};
    compute_sched(abc_blk);
    digest2 = ref_compress(ABC_DIGEST, abc_blk);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy",       256'(bus.busy), 256'(1'b0));
    chk("rst_done",       256'(bus.done), 256'(1'b0));
    chk("rst_cycle",      256'(bus.cycle), 256'(6'd0));
    chk("rst_W",          256'(bus.W), 256'(64'd0));
    chk("rst_math_input", bus.math_input, 256'd0);
    chk("rst_hash_out",   bus.hash_out, 256'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 256'(bus.busy), 256'(1'b0));

    // "abc" with the standard IV
    begin_block(sha_pkg::c_sha256_iv);
    watch_run(31, 1'b0);
    expect_done(ABC_DIGEST);
    chk("abc_word_a", 256'(bus.hash_out[31:0]),    256'(32'hba7816bf));
    chk("abc_word_h", 256'(bus.hash_out[255:224]), 256'(32'hf20015ad));

    // Back-to-back: start during the done cycle, chained from the first digest
    bus.hash_in  = ABC_DIGEST;
    bus.block_in = abc_blk;
    bus.start    = 1'b1;
    watch_run(31, 1'b0);
    expect_done(digest2);
    @(negedge clk);
    chk("done_one_cycle", 256'(bus.done), 256'(1'b0));
    chk("digest_held",    bus.hash_out, digest2);

    // Start pulses while busy are ignored
    begin_block(sha_pkg::c_sha256_iv);
    watch_run(31, 1'b1);
    bus.start = 1'b0;
    expect_done(ABC_DIGEST);

    // Abort in RUN at pair 17
    begin_block(sha_pkg::c_sha256_iv);
    watch_run(17, 1'b0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy",     256'(bus.busy), 256'(1'b0));
    chk("abort_cycle",    256'(bus.cycle), 256'(6'd0));
    chk("abort_done",     256'(bus.done), 256'(1'b0));
    chk("abort_hash_out", bus.hash_out, ABC_DIGEST);
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) done_seen = 1'b1;
    end
    chk("abort_no_done", 256'(done_seen), 256'(1'b0));

    // abort and start together in IDLE: block not accepted
    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_busy", 256'(bus.busy), 256'(1'b0));

    // Abort in FINAL: no done, digest unchanged
    begin_block(ABC_DIGEST);
    watch_run(31, 1'b0);
    @(negedge clk);
    chk("fin_abort_busy", 256'(bus.busy), 256'(1'b1));
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("fin_abort_done", 256'(bus.done), 256'(1'b0));
    chk("fin_abort_busy2", 256'(bus.busy), 256'(1'b0));
    chk("fin_abort_hash", bus.hash_out, ABC_DIGEST);

    // Asynchronous reset at RUN pair 10
    begin_block(sha_pkg::c_sha256_iv);
    watch_run(10, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_busy",       256'(bus.busy), 256'(1'b0));
    chk("arst_done",       256'(bus.done), 256'(1'b0));
    chk("arst_cycle",      256'(bus.cycle), 256'(6'd0));
    chk("arst_W",          256'(bus.W), 256'(64'd0));
    chk("arst_math_input", bus.math_input, 256'd0);
    chk("arst_hash_out",   bus.hash_out, 256'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 256'(bus.busy), 256'(1'b0));
    begin_block(sha_pkg::c_sha256_iv);
    watch_run(31, 1'b0);
    expect_done(ABC_DIGEST);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
